ctrl_pipe: RTL

CTRL_PIPE -- requirements
Module: ctrl_pipe

---
 rtl/ctrl_pkg.sv | 44 ++++
 rtl/ctrl_decode.sv | 33 +++
 rtl/ctrl_pipe.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the control pipeline.
//   - opcode constants of the 4-bit ISA
//   - FSM state encoding (RUN, DRAIN, HALTED)
//   - ctrl_t: the per-stage control bundle; the destination register travels
//     next to it as a separate field because its width is a module parameter
//   - reads_rt(): which opcodes take a source operand from rt
package ctrl_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OPC_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OPC_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_SLT  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_LW   = 4'b1000;
  localparam logic [OPC_W-1:0] OP_SW   = 4'b1001;
  localparam logic [OPC_W-1:0] OP_LUI  = 4'b1010;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JAL  = 4'b1110;
  localparam logic [OPC_W-1:0] OP_HLT  = 4'b1111;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [OPC_W-1:0] opcode;
    logic             mem_write;
    logic             mem_to_reg;
    logic             reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic reads_rt(input logic [OPC_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational decode of one instruction into control flags.
// Ports:
//   opcode     in   instruction opcode
//   rd         in   destination register specifier
//   mem_write  out  store
//   mem_to_reg out  load (write-back value comes from memory)
//   reg_write  out  writes a register (never for R0, which is hardwired zero)
//   halt       out  HLT instruction
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [REG_W-1:0] rd,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             halt
);

  logic writes_reg;

  always_comb begin
    mem_write  = (opcode == OP_SW);
    mem_to_reg = (opcode == OP_LW);
    halt       = (opcode == OP_HLT);
    writes_reg = !opcode[3] || (opcode == OP_LW) || (opcode == OP_LUI) ||
                 (opcode == OP_ADDI) || (opcode == OP_JAL);
    reg_write  = writes_reg && (rd != '0);
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control path of a 4-stage in-order pipeline (ID/EX/MEM/WB).
// Decodes the ID instruction, carries its control bundle down to WB, detects
// load-use hazards, applies branch flushes and sequences the halt.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid, id_opcode        ID-stage instruction
//   id_rs, id_rt, id_rd        ID-stage register specifiers
//   flush                      branch taken: squash the ID instruction
//   stall                      load-use hazard: IF/ID must hold
//   fetch_en                   fetch permitted
//   ex_valid, ex_opcode        EX-stage contents
//   mem_mem_write, mem_mem_to_reg          MEM-stage controls
//   wb_reg_write, wb_mem_to_reg, wb_rd     WB-stage controls
//   halted                     processor halted
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_W     = 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             flush,
  output logic             stall,
  output logic             fetch_en,
  output logic             ex_valid,
  output logic [3:0]       ex_opcode,
  output logic             mem_mem_write,
  output logic             mem_mem_to_reg,
  output logic             wb_reg_write,
  output logic             wb_mem_to_reg,
  output logic [REG_W-1:0] wb_rd,
  output logic             halted
);

  localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYC - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  ctrl_t            ex_p0, mem_p1, wb_p2;
  logic [REG_W-1:0] rd_p0, rd_p1, rd_p2;

  ctrl_t            ex_next;
  logic [REG_W-1:0] rd_next;

  logic dec_mem_write, dec_mem_to_reg, dec_reg_write, dec_halt;
  logic hazard, id_take;
  logic wb_unused;

  ctrl_decode #(.REG_W(REG_W)) u_decode (
    .opcode     (id_opcode),
    .rd         (id_rd),
    .mem_write  (dec_mem_write),
    .mem_to_reg (dec_mem_to_reg),
    .reg_write  (dec_reg_write),
    .halt       (dec_halt)
  );

  // A load in EX whose result the ID instruction needs; R0 never conflicts.
  assign hazard = ex_p0.valid && ex_p0.mem_to_reg && (rd_p0 != '0) && id_valid &&
                  ((rd_p0 == id_rs) || (reads_rt(id_opcode) && (rd_p0 == id_rt)));
  assign stall  = hazard && !flush;

  // Only RUN accepts new work into EX; DRAIN/HALTED feed bubbles.
  assign id_take = id_valid && !flush && !stall && (state == RUN);

  always_comb begin
    ex_next = CTRL_BUBBLE;
    rd_next = '0;
    if (id_take) begin
      ex_next.valid      = 1'b1;
      ex_next.opcode     = id_opcode;
      ex_next.mem_write  = dec_mem_write;
      ex_next.mem_to_reg = dec_mem_to_reg;
      ex_next.reg_write  = dec_reg_write;
      rd_next            = id_rd;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (id_take && dec_halt) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end
      end
      DRAIN: begin
        if (cnt == CNT_LAST) begin
          state_next = HALTED;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // ID -> EX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_p0 <= CTRL_BUBBLE;
      rd_p0 <= '0;
    end else begin
      ex_p0 <= ex_next;
      rd_p0 <= rd_next;
    end
  end

  // EX -> MEM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_p1 <= CTRL_BUBBLE;
      rd_p1  <= '0;
    end else begin
      mem_p1 <= ex_p0;
      rd_p1  <= rd_p0;
    end
  end

  // MEM -> WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_p2 <= CTRL_BUBBLE;
      rd_p2 <= '0;
    end else begin
      wb_p2 <= mem_p1;
      rd_p2 <= rd_p1;
    end
  end

  assign fetch_en       = (state == RUN) && !stall && !(id_valid && dec_halt);
  assign halted         = (state == HALTED);
  assign ex_valid       = ex_p0.valid;
  assign ex_opcode      = ex_p0.opcode;
  assign mem_mem_write  = mem_p1.mem_write;
  assign mem_mem_to_reg = mem_p1.mem_to_reg;
  assign wb_reg_write   = wb_p2.reg_write;
  assign wb_mem_to_reg  = wb_p2.mem_to_reg;
  assign wb_rd          = rd_p2;

  // WB fields with no consumer at this boundary.
  assign wb_unused = ^{wb_p2.valid, wb_p2.opcode, wb_p2.mem_write};

endmodule
